// File: rtl/joker_ts_filter_ctrl_mc.sv
// Multi-channel TS PID filter table controller: decodes filter sub-commands from the
// command buffer, updates the per-channel block table, and returns status. Query via TS_FILTER_QUERY_EN.
module joker_ts_filter_ctrl_mc #(
    parameter int          PID_W           = 13,
    parameter int          CHANNELS        = 4,
    parameter int          RD_LAT          = 2,
    parameter int          MAX_LIST        = 32,
    parameter logic [7:0]  J_CMD_TS_FILTER = 8'h30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          j_cmd,
    output logic                ack_o,
    input  logic [7:0]          buf_out_q,
    output logic [10:0]         buf_out_addr,
    output logic [10:0]         buf_in_addr,
    output logic [7:0]          buf_in_data,
    output logic                buf_in_wren,
    output logic [PID_W-1:0]    table_wr_address,
    output logic [CHANNELS-1:0] table_data,
    output logic [CHANNELS-1:0] table_be,
    output logic                table_wren,
    output logic [PID_W-1:0]    table_rd_address,
    input  logic [CHANNELS-1:0] table_q
);

    typedef enum logic [3:0] {
        IDLE, FETCH, CMD, MASK, DECODE, PID_A, PID_B, COUNT,
        BULK, RANGE, LIST, STATUS, DONE
`ifdef TS_FILTER_QUERY_EN
        , QUERY
`endif
    } state_t;

    state_t              state_q, state_d, ret_q, ret_d, fetch_ret;
    logic [7:0]          cnt_q, cnt_d, sub_q, sub_d, hi_q, hi_d;
    logic [7:0]          n_q, n_d, idx_q, idx_d, status_q, status_d;
    logic [CHANNELS-1:0] mask_q, mask_d, tdata_q, tdata_d, tbe_q, tbe_d;
    logic [PID_W-1:0]    pid_a_q, pid_a_d, pid_b_q, pid_b_d, cur_q, cur_d;
    logic [PID_W-1:0]    taddr_q, taddr_d, rd_addr_q, rd_addr_d, pid_in;
    logic [10:0]         baddr_q, baddr_d;
    logic                ph_q, ph_d, twren_q, twren_d, go_fetch, sub_known;

    assign pid_in           = PID_W'({hi_q, buf_out_q});
    assign ack_o            = (state_q == DONE);
    assign buf_out_addr     = baddr_q;
    assign table_wr_address = taddr_q;
    assign table_data       = tdata_q;
    assign table_be         = tbe_q;
    assign table_wren       = twren_q;

`ifdef TS_FILTER_QUERY_EN
    assign sub_known        = (sub_q <= 8'd8);
    assign table_rd_address = rd_addr_q;
`else
    assign sub_known        = (sub_q < 8'd8);
    assign table_rd_address = '0;
    logic unused_table_q;
    assign unused_table_q   = ^{table_q, rd_addr_q};
`endif

    always_comb begin
        state_d  = state_q;   ret_d    = ret_q;    cnt_d   = cnt_q;
        sub_d    = sub_q;     hi_d     = hi_q;     n_d     = n_q;
        idx_d    = idx_q;     status_d = status_q; mask_d  = mask_q;
        pid_a_d  = pid_a_q;   pid_b_d  = pid_b_q;  cur_d   = cur_q;
        taddr_d  = taddr_q;   tdata_d  = tdata_q;  tbe_d   = tbe_q;
        rd_addr_d = rd_addr_q; baddr_d = baddr_q;  ph_d    = ph_q;
        twren_d  = 1'b0;
        go_fetch = 1'b0;
        fetch_ret = IDLE;
        buf_in_wren = 1'b0;
        buf_in_addr = '0;
        buf_in_data = '0;

        case (state_q)
            IDLE: begin
                status_d = '0;
                ph_d     = 1'b0;
                if (j_cmd == J_CMD_TS_FILTER) begin
                    go_fetch = 1'b1; fetch_ret = CMD;
                end
            end
            FETCH: begin
                if (cnt_q == 8'(RD_LAT)) state_d = ret_q;
                else cnt_d = cnt_q + 8'd1;
            end
            CMD: begin
                sub_d = buf_out_q;
                go_fetch = 1'b1; fetch_ret = MASK;
            end
            MASK: begin
                mask_d  = buf_out_q[CHANNELS-1:0];
                state_d = DECODE;
            end
            DECODE: begin
                if (!sub_known) begin
                    status_d = 8'd1; state_d = STATUS;
                end else if (sub_q < 8'd8 && mask_q == '0) begin
                    status_d = 8'd2; state_d = STATUS;
                end else if (sub_q < 8'd2) begin
                    cur_d = '1; state_d = BULK;
                end else begin
                    go_fetch  = 1'b1;
                    fetch_ret = (sub_q[3:1] == 3'd3) ? COUNT : PID_A;
                end
            end
            // PID bytes arrive hi then lo; ph_q tracks which one is on buf_out_q
            PID_A: begin
                if (!ph_q) begin
                    hi_d = buf_out_q; ph_d = 1'b1;
                    go_fetch = 1'b1; fetch_ret = PID_A;
                end else begin
                    ph_d = 1'b0; pid_a_d = pid_in;
                    if (sub_q[3:1] == 3'd2) begin
                        go_fetch = 1'b1; fetch_ret = PID_B;
                    end
`ifdef TS_FILTER_QUERY_EN
                    else if (sub_q == 8'd8) begin
                        rd_addr_d = pid_in; cnt_d = '0; state_d = QUERY;
                    end
`endif
                    else begin
                        pid_b_d = pid_in; cur_d = pid_in; state_d = RANGE;
                    end
                end
            end
            PID_B: begin
                if (!ph_q) begin
                    hi_d = buf_out_q; ph_d = 1'b1;
                    go_fetch = 1'b1; fetch_ret = PID_B;
                end else begin
                    ph_d = 1'b0; pid_b_d = pid_in;
                    if (pid_a_q > pid_in) begin
                        status_d = 8'd2; state_d = STATUS;
                    end else begin
                        cur_d = pid_a_q; state_d = RANGE;
                    end
                end
            end
            COUNT: begin
                n_d = buf_out_q;
                if (buf_out_q == 8'd0 || int'(buf_out_q) > MAX_LIST) begin
                    status_d = 8'd2; state_d = STATUS;
                end else begin
                    idx_d = '0; ph_d = 1'b0;
                    go_fetch = 1'b1; fetch_ret = LIST;
                end
            end
            BULK: begin
                twren_d = 1'b1; taddr_d = cur_q;
                if (cur_q == '0) state_d = STATUS;
                else cur_d = cur_q - 1'b1;
            end
            RANGE: begin
                twren_d = 1'b1; taddr_d = cur_q;
                if (cur_q == pid_b_q) state_d = STATUS;
                else cur_d = cur_q + 1'b1;
            end
            LIST: begin
                if (!ph_q) begin
                    hi_d = buf_out_q; ph_d = 1'b1;
                    go_fetch = 1'b1; fetch_ret = LIST;
                end else begin
                    ph_d = 1'b0; twren_d = 1'b1; taddr_d = pid_in;
                    idx_d = idx_q + 8'd1;
                    if (idx_q + 8'd1 == n_q) state_d = STATUS;
                    else begin
                        go_fetch = 1'b1; fetch_ret = LIST;
                    end
                end
            end
`ifdef TS_FILTER_QUERY_EN
            QUERY: begin
                if (cnt_q == 8'd2) begin
                    buf_in_wren = 1'b1; buf_in_addr = 11'd1;
                    buf_in_data = 8'(table_q);
                    state_d = STATUS;
                end else cnt_d = cnt_q + 8'd1;
            end
`endif
            STATUS: begin
                buf_in_wren = 1'b1; buf_in_addr = 11'd0;
                buf_in_data = status_q;
                state_d = DONE;
            end
            DONE: if (j_cmd != J_CMD_TS_FILTER) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Command bytes are consumed strictly in address order, so every fetch is addr+1
        if (go_fetch) begin
            state_d = FETCH; ret_d = fetch_ret; cnt_d = '0;
            baddr_d = (state_q == IDLE) ? 11'd1 : baddr_q + 11'd1;
        end
        if (twren_d) begin
            tdata_d = {CHANNELS{sub_q[0]}};
            tbe_d   = mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;  ret_q <= IDLE;  cnt_q <= '0;   sub_q <= '0;
            hi_q <= '0;       n_q <= '0;      idx_q <= '0;   status_q <= '0;
            mask_q <= '0;     pid_a_q <= '0;  pid_b_q <= '0; cur_q <= '0;
            taddr_q <= '0;    tdata_q <= '0;  tbe_q <= '0;   twren_q <= 1'b0;
            rd_addr_q <= '0;  baddr_q <= '0;  ph_q <= 1'b0;
        end else begin
            state_q <= state_d;  ret_q <= ret_d;     cnt_q <= cnt_d;     sub_q <= sub_d;
            hi_q <= hi_d;        n_q <= n_d;         idx_q <= idx_d;     status_q <= status_d;
            mask_q <= mask_d;    pid_a_q <= pid_a_d; pid_b_q <= pid_b_d; cur_q <= cur_d;
            taddr_q <= taddr_d;  tdata_q <= tdata_d; tbe_q <= tbe_d;     twren_q <= twren_d;
            rd_addr_q <= rd_addr_d; baddr_q <= baddr_d; ph_q <= ph_d;
        end
    end

endmodule

// File: tb/tb_joker_ts_filter_ctrl_mc.sv
// Bench for joker_ts_filter_ctrl_mc: buffer/table memory models plus a rule-level
// reference of expected writes, status and query replies.
module tb_joker_ts_filter_ctrl_mc;
    localparam int PID_W = 13, CH = 4, RD_LAT = 2, MAX_LIST = 32, DEPTH = 1 << PID_W;
    localparam logic [7:0] JCMD = 8'h30;
`ifdef TS_FILTER_QUERY_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] j_cmd = 8'h00, buf_out_q, buf_in_data;
    logic ack_o, buf_in_wren, table_wren;
    logic [10:0] buf_out_addr, buf_in_addr;
    logic [PID_W-1:0] table_wr_address, table_rd_address;
    logic [CH-1:0] table_data, table_be, table_q;

    always #5 clk = ~clk;

    joker_ts_filter_ctrl_mc #(.PID_W(PID_W), .CHANNELS(CH), .RD_LAT(RD_LAT),
                              .MAX_LIST(MAX_LIST), .J_CMD_TS_FILTER(JCMD)) dut (
        .clk(clk), .reset(reset), .j_cmd(j_cmd), .ack_o(ack_o),
        .buf_out_q(buf_out_q), .buf_out_addr(buf_out_addr),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .table_wr_address(table_wr_address), .table_data(table_data), .table_be(table_be),
        .table_wren(table_wren), .table_rd_address(table_rd_address), .table_q(table_q));

    typedef struct packed {
        logic [PID_W-1:0] a;
        logic [CH-1:0]    d;
        logic [CH-1:0]    be;
    } wr_t;

    logic [7:0]    cmd_mem [2048];
    logic [7:0]    bp [RD_LAT];
    logic [CH-1:0] tbl [DEPTH] = '{default: '0};
    logic [CH-1:0] exp_tbl [DEPTH] = '{default: '0};
    logic [CH-1:0] tq1, tq2;
    logic [7:0]    reply [2];
    logic [15:0]   lpid [64];
    wr_t act_q[$], exp_q[$];
    int  n_reply = 0, ack_cnt = 0, n_tests = 0, n_fail = 0;

    always @(posedge clk) begin
        bp[0] <= cmd_mem[buf_out_addr];
        for (int k = 1; k < RD_LAT; k++) bp[k] <= bp[k-1];
        tq1 <= tbl[table_rd_address];
        tq2 <= tq1;
    end
    assign buf_out_q = bp[RD_LAT-1];
    assign table_q   = tq2;

    always @(negedge clk) begin
        if (table_wren) begin
            act_q.push_back(wr_t'{table_wr_address, table_data, table_be});
            tbl[table_wr_address] <= (tbl[table_wr_address] & ~table_be) | (table_data & table_be);
        end
        if (buf_in_wren) begin
            if (buf_in_addr < 11'd2) reply[buf_in_addr[0]] <= buf_in_data;
            n_reply <= n_reply + 1;
        end
        if (ack_o) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_exp();
        foreach (exp_q[i])
            exp_tbl[exp_q[i].a] = (exp_tbl[exp_q[i].a] & ~exp_q[i].be) | (exp_q[i].d & exp_q[i].be);
    endtask

    // Reference: what the table/reply should see for one command, from the sub-command rules
    task automatic model(input logic [7:0] sub, input logic [7:0] mb, input logic [15:0] a,
                         input logic [15:0] b, input int n,
                         output logic [7:0] st, output logic [7:0] qv);
        logic [CH-1:0] m, pat;
        int pa, pb;
        m = mb[CH-1:0]; pat = sub[0] ? '1 : '0;
        pa = int'(a) % DEPTH; pb = int'(b) % DEPTH;
        exp_q.delete(); st = 8'd0; qv = 8'd0;
        if (sub > 8 || (sub == 8 && !QEN)) st = 8'd1;
        else if (sub < 8 && m == 0) st = 8'd2;
        else if (sub < 2) for (int p = DEPTH - 1; p >= 0; p--) exp_q.push_back(wr_t'{PID_W'(p), pat, m});
        else if (sub < 4) exp_q.push_back(wr_t'{PID_W'(pa), pat, m});
        else if (sub < 6) begin
            if (pa > pb) st = 8'd2;
            else for (int p = pa; p <= pb; p++) exp_q.push_back(wr_t'{PID_W'(p), pat, m});
        end else if (sub < 8) begin
            if (n == 0 || n > MAX_LIST) st = 8'd2;
            else for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{PID_W'(int'(lpid[i]) % DEPTH), pat, m});
        end else qv = 8'(exp_tbl[pa]);
        apply_exp();
    endtask

    task automatic run_cmd(input logic [7:0] sub, input logic [7:0] mb, input logic [15:0] a,
                           input logic [15:0] b, input int n, input bit early);
        logic [7:0] st, qv;
        int base, rbase, abase, bad, diff, lim;
        cmd_mem[1] = sub; cmd_mem[2] = mb;
        if (sub == 8'd6 || sub == 8'd7) begin
            cmd_mem[3] = 8'(n);
            for (int i = 0; i < 40; i++) begin
                cmd_mem[4 + 2*i] = lpid[i][15:8];
                cmd_mem[5 + 2*i] = lpid[i][7:0];
            end
        end else begin
            cmd_mem[3] = a[15:8]; cmd_mem[4] = a[7:0];
            cmd_mem[5] = b[15:8]; cmd_mem[6] = b[7:0];
        end
        model(sub, mb, a, b, n, st, qv);
        base = act_q.size(); rbase = n_reply; abase = ack_cnt;
        j_cmd = JCMD;
        if (early) begin
            repeat (3) @(negedge clk);
            j_cmd = 8'h00;
        end
        for (int c = 0; c < 20000 && !ack_o; c++) @(negedge clk);
        chk("ack_seen", ack_o, 1);
        j_cmd = 8'h00;
        repeat (4) @(negedge clk);
        chk("ack_len", ack_cnt - abase, 1);
        chk("n_wr", act_q.size() - base, exp_q.size());
        bad = 0;
        lim = (act_q.size() - base < exp_q.size()) ? act_q.size() - base : exp_q.size();
        for (int i = 0; i < lim; i++) if (act_q[base + i] !== exp_q[i]) bad++;
        chk("wr_seq", bad, 0);
        chk("status", reply[0], st);
        chk("n_reply", n_reply - rbase, (sub == 8'd8 && QEN) ? 2 : 1);
        if (sub == 8'd8 && QEN) chk("query", reply[1], qv);
        diff = 0;
        for (int p = 0; p < DEPTH; p++) if (tbl[p] !== exp_tbl[p]) diff++;
        chk("table", diff, 0);
    endtask

    initial begin
        logic [7:0] sub;
        logic [15:0] a, b;
        int base, bad, found, cnt;
        for (int i = 0; i < 2048; i++) cmd_mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_strobes", {table_wren, buf_in_wren, ack_o}, 0);
        chk("rst_baddr", {buf_out_addr, buf_in_addr, buf_in_data}, 0);
        chk("rst_tbl", {table_wr_address, table_data, table_be}, 0);
        chk("rst_rd", table_rd_address, 0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(8'd1, 8'h0F, 16'h0, 16'h0, 0, 1'b0);
        run_cmd(8'd3, 8'h02, 16'hFFFF, 16'h0, 0, 1'b0);
        run_cmd(8'd4, 8'h01, 16'h0100, 16'h0103, 0, 1'b0);
        run_cmd(8'd4, 8'h01, 16'h0105, 16'h0100, 0, 1'b1);
        lpid[0] = 16'h0011; lpid[1] = 16'h0022; lpid[2] = 16'h0033;
        run_cmd(8'd7, 8'h04, 16'h0, 16'h0, 3, 1'b0);
        run_cmd(8'd7, 8'h04, 16'h0, 16'h0, 33, 1'b0);
        run_cmd(8'd6, 8'h04, 16'h0, 16'h0, 0, 1'b0);
        run_cmd(8'd9, 8'h0F, 16'h0, 16'h0, 0, 1'b0);
        run_cmd(8'd2, 8'h00, 16'h0040, 16'h0, 0, 1'b0);
        run_cmd(8'd2, 8'h0F, 16'h0100, 16'h0, 0, 1'b0);
        run_cmd(8'd3, 8'h05, 16'h0100, 16'h0, 0, 1'b0);
        run_cmd(8'd8, 8'h00, 16'h0100, 16'h0, 0, 1'b0);
        run_cmd(8'd4, 8'h0C, 16'h0020, 16'h0020, 0, 1'b0);
        run_cmd(8'd5, 8'h03, 16'hFFF9, 16'hFFFF, 0, 1'b1);

        // Reset in the middle of a bulk write: written entries stay, the rest never happen
        cmd_mem[1] = 8'd1; cmd_mem[2] = 8'h0A;
        base = act_q.size(); found = 0;
        j_cmd = JCMD;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (table_wren && table_wr_address == PID_W'(4000)) begin
                found = 1;
                break;
            end
        end
        chk("rst_hit", found, 1);
        reset = 1'b1; j_cmd = 8'h00;
        @(negedge clk);
        chk("rst_mid_wren", table_wren, 0);
        chk("rst_mid_ack", ack_o, 0);
        chk("rst_mid_reply", buf_in_wren, 0);
        reset = 1'b0;
        @(negedge clk);
        cnt = act_q.size() - base;
        chk("rst_n_wr", cnt, DEPTH - 4000);
        exp_q.delete();
        for (int p = DEPTH - 1; p >= 4000; p--) exp_q.push_back(wr_t'{PID_W'(p), 4'hF, 4'hA});
        apply_exp();
        bad = 0;
        for (int i = 0; i < cnt && i < exp_q.size(); i++) if (act_q[base + i] !== exp_q[i]) bad++;
        chk("rst_wr_seq", bad, 0);
        run_cmd(8'd2, 8'h0F, 16'h1234, 16'h0, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            sub = 8'($urandom_range(2, 10));
            if (sub == 8'd10) sub = 8'($urandom_range(9, 255));
            a = 16'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                cnt = int'(a[PID_W-1:0]) + int'($urandom_range(0, 15));
                if (cnt > DEPTH - 1) cnt = DEPTH - 1;
                b = {3'($urandom), PID_W'(cnt)};
            end else b = 16'($urandom);
            for (int i = 0; i < 40; i++) lpid[i] = 16'($urandom);
            run_cmd(sub, 8'($urandom), a, b, int'($urandom_range(0, 35)), 1'($urandom));
        end
        run_cmd(8'd0, 8'($urandom_range(1, 15)), 16'h0, 16'h0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/joker_ts_filter_ctrl_mc.md
Name: joker_ts_filter_ctrl_mc

Overview:
Multi-channel, parametrised TS PID filter table controller. It decodes TS-filter sub-commands from the EP2 OUT command buffer and updates a PID filter table holding one block bit per output channel per PID, using per-bit write enables. Adds range, list and query sub-commands and a status/reply path back to the host. Sits between the joker control dispatcher (j_cmd/ack_o handshake) and the TS filter table RAM.

Parameters:
PID_W, 13, PID width; table depth is 2^PID_W
CHANNELS, 4, number of filter channels; table data width; 1 = block
RD_LAT, 2, command-buffer read latency in cycles (buf_out_addr to valid buf_out_q)
MAX_LIST, 32, maximum PID count accepted by list sub-commands

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
j_cmd  in  8  dispatcher command; block is active while j_cmd == J_CMD_TS_FILTER
ack_o  out  1  command complete
buf_out_q  in  8  command buffer read data
buf_out_addr  out  11  command buffer read address
buf_in_addr  out  11  reply buffer write address
buf_in_data  out  8  reply buffer write data
buf_in_wren  out  1  reply buffer write strobe
table_wr_address  out  PID_W  table write address
table_data  out  CHANNELS  table write data
table_be  out  CHANNELS  per-channel bit write enable
table_wren  out  1  table write strobe
table_rd_address  out  PID_W  table read address (query)
table_q  in  CHANNELS  table read data, valid 2 cycles after address

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-operation aborts at the next edge: wren deasserted, no rollback of entries already written.
- Buffer layout:
  - byte1: sub-cmd
  - byte2: channel mask (low CHANNELS bits)
  - bytes3/4: PID A hi/lo
  - bytes5/6: PID B hi/lo
  - list sub-cmds: byte3 = count N; PIDs at bytes 4+2i (hi) and 5+2i (lo)
- Byte fetch: set buf_out_addr, sample buf_out_q exactly RD_LAT+1 cycles later. A PID is {hi,lo} truncated to PID_W bits.
- Sub-cmds (even = allow, data 0; odd = block, data 1; table_be = mask):
  - 0/1: all PIDs
  - 2/3: PID A
  - 4/5: inclusive range A..B
  - 6/7: list of N PIDs
  - 8: query PID A
- Every table write: table_data = {CHANNELS{pattern}}, table_be = mask, table_wren held 1 cycle per entry.
- Write order:
  - Bulk: addresses 2^PID_W-1 down to 0, one per cycle, exactly 2^PID_W writes.
  - Range: A ascending to B, one per cycle.
  - List: one write per PID after its lo byte is fetched.
- Query: drive table_rd_address = A, wait 2 cycles, write table_q (zero-extended) to reply address 1.
- Status, always written to reply address 0 before DONE (one buf_in_wren cycle):
  - 0 = OK
  - 1 = unknown sub-cmd
  - 2 = bad argument: mask == 0 (sub-cmds 0-7), A > B, N == 0, or N > MAX_LIST
- Status 1 and 2 perform no table writes.
- FSM states: IDLE, FETCH (wait RD_LAT+1, return to caller state), CMD, MASK, DECODE, PID_A, PID_B, COUNT, BULK, RANGE, LIST, QUERY, STATUS, DONE.
- Transitions:
  - IDLE -> CMD on j_cmd == J_CMD_TS_FILTER.
  - DONE: table_wren = 0, ack_o = 1; go to IDLE when j_cmd != J_CMD_TS_FILTER.
  - If j_cmd drops mid-command, the operation still completes. ack_o is then high for exactly one cycle.
- Boundaries:
  - Range with A == B: one write.
  - Range B = 2^PID_W-1 terminates without address wrap.
  - Bulk address decrement from 0 must not cause an extra write.

Optional Feature:
Macro TS_FILTER_QUERY_EN.
- Defined: sub-cmd 8 is supported as described.
- Undefined: sub-cmd 8 returns status 1; table_rd_address is tied to 0; table_q is unused; the QUERY state is not built.

Test Plan:
- Sub-cmd 1, mask 0xF, PID_W=13 -> table_wren high for exactly 8192 cycles, addresses 8191..0, data 0xF, be 0xF; status 0; ack_o.
- Sub-cmd 3, mask 0x2, PID 0x1FFF (hi byte 0xFF truncated) -> single write at address 0x1FFF, data 0xF, be 0x2; status 0.
- Sub-cmd 4, mask 0x1, A=0x100, B=0x103 -> 4 writes at 0x100..0x103 with data 0, be 0x1; A=0x105, B=0x100 -> no writes, status 2.
- Sub-cmd 7, mask 0x4, N=3, PIDs 0x11/0x22/0x33 -> 3 writes in order; N=33 -> no writes, status 2; sub-cmd 9 -> status 1.
- Query PID 0x100 after block on channels 0 and 2 -> reply addr1 = 0x05, addr0 = 0 (with TS_FILTER_QUERY_EN); without the macro -> status 1.
- Assert reset mid-bulk at address 4000 -> next cycle table_wren = 0, ack_o = 0, FSM in IDLE; a following sub-cmd 2 completes normally.
